// File: rtl/axi_lite_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO slave: register offsets, response
// codes, FSM state encodings and address/strobe helpers.
package axi_lite_gpio_pkg;

    localparam logic [31:0] ADDR_OUT        = 32'h0000_0000;
    localparam logic [31:0] ADDR_DIR        = 32'h0000_0004;
    localparam logic [31:0] ADDR_IN         = 32'h0000_0008;
    localparam logic [31:0] ADDR_IRQ_STATUS = 32'h0000_000C;
    localparam logic [31:0] ADDR_IRQ_EN     = 32'h0000_0010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_NEED_W = 2'd1,
        W_NEED_A = 2'd2,
        W_RESP   = 2'd3
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef enum logic [2:0] {
        REG_OUT        = 3'd0,
        REG_DIR        = 3'd1,
        REG_IN         = 3'd2,
        REG_IRQ_STATUS = 3'd3,
        REG_IRQ_EN     = 3'd4,
        REG_NONE       = 3'd5
    } reg_sel_e;

    // Byte address to register select; the two low address bits are ignored.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr & 32'hFFFF_FFFC)
            ADDR_OUT:        sel = REG_OUT;
            ADDR_DIR:        sel = REG_DIR;
            ADDR_IN:         sel = REG_IN;
            ADDR_IRQ_STATUS: sel = REG_IRQ_STATUS;
            ADDR_IRQ_EN:     sel = REG_IRQ_EN;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = strb[k] ? 8'hFF : 8'h00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_lite_gpio_slave_sync.sv
// Two-flop synchronizer for the GPIO input pins plus a third flop used to
// detect rising edges of the synchronized value.
module gpio_in_sync
    import axi_lite_gpio_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    // Next-state of the synchronizer chain.
    always_comb begin
        meta_d = pin_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-detect flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
            prev_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/axi_lite_gpio_slave.sv
// AXI4-Lite slave exposing a GPIO register bank (OUT, DIR, IN, IRQ_STATUS,
// IRQ_EN) with independent single-outstanding read and write channels.
module axi_lite_gpio_slave
    import axi_lite_gpio_pkg::*;
#(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  s_axi_aclock,
    input  logic                  s_axi_areset,
    input  logic [31:0]           s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    wr_state_e              wr_state_q, wr_state_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    reg_sel_e               aw_sel_q, aw_sel_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             wstrb_q, wstrb_d;

    rd_state_e              rd_state_q, rd_state_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic [GPIO_WIDTH-1:0]  out_q, out_d;
    logic [GPIO_WIDTH-1:0]  dir_q, dir_d;
    logic [GPIO_WIDTH-1:0]  stat_q, stat_d;
    logic [GPIO_WIDTH-1:0]  en_q, en_d;
    logic                   irq_q, irq_d;

    logic [GPIO_WIDTH-1:0]  in_sync_s, in_rise_s;
    logic                   aw_hs_s, w_hs_s, ar_hs_s;
    logic                   wr_commit_s, wr_err_s;
    logic [31:0]            wr_mask32_s;
    logic [GPIO_WIDTH-1:0]  wr_mask_s, wr_val_s;
    reg_sel_e               rd_sel_s;
    logic [31:0]            rd_val_s;

    function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    gpio_in_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync (
        .clk    (s_axi_aclock),
        .rst    (s_axi_areset),
        .pin_i  (gpio_in),
        .sync_o (in_sync_s),
        .rise_o (in_rise_s)
    );

    assign aw_hs_s = s_axi_awvalid & awready_q;
    assign w_hs_s  = s_axi_wvalid & wready_q;
    assign ar_hs_s = s_axi_arvalid & arready_q;

    // Write FSM next state; the commit pulse marks the entry into W_RESP.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_commit_s = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    wr_state_d  = W_RESP;
                    wr_commit_s = 1'b1;
                end else if (aw_hs_s) begin
                    wr_state_d = W_NEED_W;
                end else if (w_hs_s) begin
                    wr_state_d = W_NEED_A;
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_NEED_W: begin
                if (w_hs_s) begin
                    wr_state_d  = W_RESP;
                    wr_commit_s = 1'b1;
                end else begin
                    wr_state_d = W_NEED_W;
                end
            end
            W_NEED_A: begin
                if (aw_hs_s) begin
                    wr_state_d  = W_RESP;
                    wr_commit_s = 1'b1;
                end else begin
                    wr_state_d = W_NEED_A;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = W_IDLE;
                end else begin
                    wr_state_d = W_RESP;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Capture address/data on their handshakes; the _d view is what commits.
    always_comb begin
        if (aw_hs_s) begin
            aw_sel_d = decode_addr(s_axi_awaddr);
        end else begin
            aw_sel_d = aw_sel_q;
        end
        if (w_hs_s) begin
            wdata_d = s_axi_wdata;
            wstrb_d = s_axi_wstrb;
        end else begin
            wdata_d = wdata_q;
            wstrb_d = wstrb_q;
        end
        wr_err_s = (aw_sel_d == REG_NONE) || (aw_sel_d == REG_IN);
        if (wr_commit_s) begin
            bresp_d = wr_err_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
            bresp_d = bresp_q;
        end
        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_NEED_A);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_NEED_W);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    // Write channel flops.
    always_ff @(posedge s_axi_aclock or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_sel_q   <= REG_NONE;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            aw_sel_q   <= aw_sel_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign wr_mask32_s = strb_to_mask(wstrb_d);
    assign wr_mask_s   = wr_mask32_s[GPIO_WIDTH-1:0];
    assign wr_val_s    = wdata_d[GPIO_WIDTH-1:0];

    // Register bank update; a new input edge overrides a same-cycle W1C.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        en_d   = en_q;
        stat_d = stat_q;
        if (wr_commit_s) begin
            case (aw_sel_d)
                REG_OUT:        out_d  = (out_q & ~wr_mask_s) | (wr_val_s & wr_mask_s);
                REG_DIR:        dir_d  = (dir_q & ~wr_mask_s) | (wr_val_s & wr_mask_s);
                REG_IRQ_EN:     en_d   = (en_q & ~wr_mask_s) | (wr_val_s & wr_mask_s);
                REG_IRQ_STATUS: stat_d = stat_q & ~(wr_val_s & wr_mask_s);
                default:        out_d  = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
        stat_d = stat_d | in_rise_s;
        irq_d  = |(stat_q & en_q);
    end

    // Register bank flops.
    always_ff @(posedge s_axi_aclock or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            out_q  <= {GPIO_WIDTH{1'b0}};
            dir_q  <= {GPIO_WIDTH{1'b0}};
            stat_q <= {GPIO_WIDTH{1'b0}};
            en_q   <= {GPIO_WIDTH{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            stat_q <= stat_d;
            en_q   <= en_d;
            irq_q  <= irq_d;
        end
    end

    // Read data mux reads current register values, so a same-cycle write is not visible.
    always_comb begin
        rd_sel_s = decode_addr(s_axi_araddr);
        case (rd_sel_s)
            REG_OUT:        rd_val_s = zext(out_q);
            REG_DIR:        rd_val_s = zext(dir_q);
            REG_IN:         rd_val_s = zext(in_sync_s);
            REG_IRQ_STATUS: rd_val_s = zext(stat_q);
            REG_IRQ_EN:     rd_val_s = zext(en_q);
            default:        rd_val_s = 32'h0;
        endcase
    end

    // Read FSM next state and response capture.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_DATA;
                    rdata_d    = rd_val_s;
                    rresp_d    = (rd_sel_s == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DATA;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_DATA);
    end

    // Read channel flops.
    always_ff @(posedge s_axi_aclock or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign gpio_out      = out_q;
    assign gpio_oe       = dir_q;
    assign irq           = irq_q;

endmodule
